// File: rtl/doodle_jump_ctrl.sv
// Game-flow FSM (idle/play/pause) driven by keycodes, plus the cascaded
// jump-duration counters feeding the physics path.
module doodle_jump_ctrl #(
  parameter logic [7:0] KEY_START = 8'h28,
  parameter logic [7:0] KEY_PAUSE = 8'h13,
  parameter logic [7:0] KEY_QUIT  = 8'h29
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       jump_reset,
  input  logic       jump_enable,
  output logic [6:0] count,
  output logic [1:0] count2,
  output logic [2:0] outstate,
  output logic       loadplat
);

  localparam int unsigned COUNT_W  = 7;
  localparam int unsigned COUNT2_W = 2;
  localparam int unsigned KEY_W    = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    PLAY  = 3'b001,
    PAUSE = 3'b010
  } state_t;

  state_t           state, state_next;
  logic             loadplat_next;
  logic [KEY_W-1:0] prev_keycode;
  logic             pause_event;

  // Edge-detect the pause key so a held key toggles only once
  assign pause_event = (keycode == KEY_PAUSE) && (prev_keycode != KEY_PAUSE);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      loadplat     <= 1'b0;
      prev_keycode <= KEY_W'(0);
    end else begin
      state        <= state_next;
      loadplat     <= loadplat_next;
      prev_keycode <= keycode;
    end
  end

  always_comb begin
    state_next    = state;
    loadplat_next = 1'b0;
    case (state)
      IDLE: begin
        if (keycode == KEY_START) begin
          state_next    = PLAY;
          loadplat_next = 1'b1;
        end
      end
      PLAY: begin
        if (keycode == KEY_QUIT) begin
          state_next = IDLE;
        end else if (pause_event) begin
          state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (keycode == KEY_QUIT) begin
          state_next = IDLE;
        end else if (pause_event) begin
          state_next = PLAY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign outstate = state;

  // count2 keys off the pre-edge MSB of count, so it lags count by one edge
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      count  <= COUNT_W'(0);
      count2 <= COUNT2_W'(0);
    end else if (jump_reset) begin
      count  <= COUNT_W'(0);
      count2 <= COUNT2_W'(0);
    end else begin
      if (jump_enable) begin
        count <= count + COUNT_W'(1);
      end
      if (count[COUNT_W-1]) begin
        count2 <= count2 + COUNT2_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_doodle_jump_ctrl.sv
// Randomized and directed checks of doodle_jump_ctrl against a behavioural model.
module tb_doodle_jump_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode;
  logic       jump_reset;
  logic       jump_enable;
  logic [6:0] count;
  logic [1:0] count2;
  logic [2:0] outstate;
  logic       loadplat;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (plain integers)
  int m_count, m_count2, m_state, m_prev, m_load;

  doodle_jump_ctrl dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .keycode     (keycode),
    .jump_reset  (jump_reset),
    .jump_enable (jump_enable),
    .count       (count),
    .count2      (count2),
    .outstate    (outstate),
    .loadplat    (loadplat)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_count2 = 0; m_state = 0; m_prev = 0; m_load = 0;
  endtask

  // One frame of game rules, using the inputs present at the edge
  task automatic model_edge();
    int k;
    int old_count;
    k = int'(keycode);
    old_count = m_count;
    m_load = 0;
    if (m_state == 0) begin
      if (k == 'h28) begin
        m_state = 1;
        m_load  = 1;
      end
    end else if (k == 'h29) begin
      m_state = 0;
    end else if (k == 'h13 && m_prev != 'h13) begin
      m_state = (m_state == 1) ? 2 : 1;
    end
    m_prev = k;
    if (jump_reset) begin
      m_count  = 0;
      m_count2 = 0;
    end else begin
      if (jump_enable) m_count = (m_count + 1) % 128;
      if (old_count >= 64) m_count2 = (m_count2 + 1) % 4;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"},    32'(count),    32'(m_count));
    check({tag, ".count2"},   32'(count2),   32'(m_count2));
    check({tag, ".outstate"}, 32'(outstate), 32'(m_state));
    check({tag, ".loadplat"}, 32'(loadplat), 32'(m_load));
  endtask

  task automatic cyc(input string tag, input logic [7:0] k, input logic en, input logic jr);
    keycode     = k;
    jump_enable = en;
    jump_reset  = jr;
    @(posedge frame_clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset(input string tag);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    logic [7:0] k;
    Reset = 1'b1;
    keycode = 8'h00;
    jump_enable = 1'b0;
    jump_reset = 1'b0;
    repeat (2) @(posedge frame_clk);
    #1;
    model_reset();
    check_all("reset");
    Reset = 1'b0;
    cyc("idle", 8'h00, 1'b0, 1'b0);

    // Start and one-cycle loadplat
    cyc("start", 8'h28, 1'b0, 1'b0);
    check("start.loadplat_hi", 32'(loadplat), 32'd1);
    cyc("start_after", 8'h00, 1'b0, 1'b0);
    check("start.loadplat_lo", 32'(loadplat), 32'd0);

    // Held pause toggles once, then re-press resumes without loadplat
    repeat (5) cyc("pause_hold", 8'h13, 1'b0, 1'b0);
    check("pause_hold.state", 32'(outstate), 32'd2);
    cyc("pause_rel", 8'h00, 1'b0, 1'b0);
    cyc("resume", 8'h13, 1'b0, 1'b0);
    check("resume.state", 32'(outstate), 32'd1);
    cyc("resume_rel", 8'h00, 1'b0, 1'b0);
    cyc("pause2", 8'h13, 1'b0, 1'b0);
    cyc("quit_pause", 8'h29, 1'b0, 1'b0);
    check("quit_pause.state", 32'(outstate), 32'd0);

    // Quit from play, then held start re-enters with another loadplat
    cyc("start2", 8'h28, 1'b0, 1'b0);
    cyc("quit_play", 8'h29, 1'b0, 1'b0);
    cyc("hold_start", 8'h28, 1'b0, 1'b0);
    cyc("hold_start2", 8'h28, 1'b0, 1'b0);
    cyc("hold_quit", 8'h29, 1'b0, 1'b0);
    cyc("hold_reenter", 8'h28, 1'b0, 1'b0);
    check("reenter.loadplat", 32'(loadplat), 32'd1);
    cyc("idle_key", 8'h00, 1'b0, 1'b0);

    // Counter enable, then reset priority
    cyc("clr", 8'h00, 1'b0, 1'b1);
    repeat (70) cyc("en70", 8'h00, 1'b1, 1'b0);
    check("en70.count", 32'(count), 32'd70);
    check("en70.count2", 32'(count2), 32'd2);
    cyc("jr_pri", 8'h00, 1'b1, 1'b1);

    // Full wrap and hold
    repeat (128) cyc("wrap", 8'h00, 1'b1, 1'b0);
    check("wrap.count", 32'(count), 32'd0);
    check("wrap.count2", 32'(count2), 32'd0);
    repeat (3) cyc("hold", 8'h00, 1'b0, 1'b0);

    // Async reset mid-play with count=50
    cyc("clr2", 8'h28, 1'b0, 1'b1);
    repeat (50) cyc("to50", 8'h00, 1'b1, 1'b0);
    check("to50.count", 32'(count), 32'd50);
    async_reset("async");
    cyc("post_async", 8'h00, 1'b0, 1'b0);

    // Randomized traffic
    k = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 11));
      case (r)
        0, 1, 2: k = 8'h00;
        3:       k = 8'h28;
        4, 5:    k = 8'h13;
        6:       k = 8'h29;
        7, 8:    k = k;
        default: k = 8'($urandom);
      endcase
      cyc("rand", k, ($urandom_range(0, 9) < 8), ($urandom_range(0, 199) == 0));
      if ($urandom_range(0, 499) == 0) async_reset("rand_async");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/doodle_jump_ctrl.md
# doodle_jump_ctrl

Game-flow and jump-timing controller for the Doodle Jump physics path. It combines a keyboard-driven game-state machine with a cascaded jump-duration counter pair. The physics block consumes `outstate` to select idle, play or pause behaviour, and consumes `loadplat` to reload the platform set. The counter outputs give the physics block a frame-based airtime measure and a 2-bit gravity increment.

## Interface
Parameters:
- KEY_START, 8'h28, keycode (Enter) that starts play from IDLE.
- KEY_PAUSE, 8'h13, keycode ('P') that toggles PLAY/PAUSE.
- KEY_QUIT, 8'h29, keycode (Esc) that returns to IDLE from any state.

Ports:
- frame_clk  in  1  frame-rate clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- keycode  in  8  current USB HID keycode; 8'h00 means no key is pressed.
- jump_reset  in  1  synchronous clear of both jump counters.
- jump_enable  in  1  increment enable for the primary jump counter.
- count  out  7  primary jump counter.
- count2  out  2  secondary counter; advances while count[6]=1.
- outstate  out  3  game state: 3'b000 IDLE, 3'b001 PLAY, 3'b010 PAUSE.
- loadplat  out  1  one-cycle pulse requesting a platform reload.

## Operation
Counters:
- count (7 bits):
  - jump_reset=1: count ← 0. jump_reset has priority over jump_enable.
  - Otherwise, jump_enable=1: count ← count+1, wrapping 127→0.
  - Otherwise: count holds.
- count2 (2 bits):
  - jump_reset=1: count2 ← 0.
  - Otherwise, count[6]=1 (the registered value, before this edge's update): count2 ← count2+1, wrapping 3→0.
  - Otherwise: count2 holds.
- Both counters run independently of outstate.

State machine (registered outstate):
- IDLE (000):
  - keycode==KEY_START → PLAY. loadplat=1 on the same edge.
- PLAY (001):
  - Pause-key press event → PAUSE.
  - keycode==KEY_QUIT → IDLE.
- PAUSE (010):
  - Pause-key press event → PLAY. No loadplat.
  - keycode==KEY_QUIT → IDLE.
- Any other encoding → IDLE on the next edge, defensively.

Pause-key press event:
- Defined as keycode==KEY_PAUSE this cycle while the registered previous keycode≠KEY_PAUSE.
- A held key therefore toggles exactly once.
- The previous-keycode register resets to 8'h00.

Other key handling:
- KEY_QUIT takes priority over the pause event in the same cycle.
- KEY_START is level-sensitive but only acts in IDLE.
- Unlisted keycodes are ignored in all states.

## Timing
Reset values (asynchronous Reset=1):
- count=0, count2=0.
- outstate=IDLE (000).
- loadplat=0.
- Previous-keycode register = 8'h00.

Latencies and pulses:
- Counter update latency: 1 frame_clk edge from jump_enable / jump_reset.
- count2 first increments on the edge after count reaches 64. It then increments every edge through count=127, i.e. 64 increments per 128-count period, which is 0 net mod 4.
- State change latency: 1 edge after a qualifying keycode is sampled.
- loadplat is high for exactly one cycle: the first cycle outstate reads PLAY after leaving IDLE. It is 0 in all other cycles, including PAUSE→PLAY.

Reset and re-entry:
- Reset asserted mid-play clears all state immediately. No loadplat is emitted on reset.
- A new start requires KEY_START again after Reset deasserts.
- Holding KEY_START through QUIT→IDLE re-enters PLAY on the next edge, with another loadplat pulse.

## Test plan
- Reset and start:
  - Apply Reset, then release with keycode=00 → outstate=000, count=0, count2=0, loadplat=0.
  - Then keycode=28 for one cycle → outstate=001 and loadplat=1 for exactly one cycle.
- Pause toggle:
  - In PLAY, hold keycode=13 for 5 cycles → outstate=010 once and stays 010.
  - Release to 00, then press 13 again → 001, loadplat stays 0.
- Quit priority:
  - In PAUSE, keycode=29 → outstate=000 next edge.
  - In PLAY, with a pause event and quit in the same cycle → 000.
- Counter enable and reset:
  - jump_enable=1 for 70 cycles from 0 → count=70, count2=6 mod 4=2.
  - Then jump_reset=1 together with jump_enable=1 → count=0, count2=0.
- Counter wrap:
  - jump_enable=1 for 128 cycles from 0 → count=0, count2=0.
  - jump_enable=0 → all values hold.
- Asynchronous reset mid-operation:
  - In PLAY with count=50, pulse Reset between clock edges → count=0 and outstate=000 before the next edge, loadplat=0.
